store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 10 +
 rtl/store_buffer_match.sv | 27 ++
 rtl/store_buffer.sv | 92 +++++++++
 tb/tb_store_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared store-buffer constants and entry record.
package sb_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_match.sv
// store_buffer_match: youngest-entry word-address match for load forwarding.
module store_buffer_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                  ents [DEPTH],
  input  logic [DEPTH-1:0]           valid,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [$clog2(DEPTH):0]     count,
  input  logic [29:0]                ld_word,
  output logic                       hit,
  output logic [31:0]                data
);
  localparam int PW = $clog2(DEPTH);
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count && valid[head + PW'(i)] && ents[head + PW'(i)].addr == ld_word) begin
        hit = 1'b1;
        data = ents[head + PW'(i)].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order circular store buffer draining straight to data memory,
// with youngest-match load forwarding.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     StReq,
  input  logic [31:0]              StAddr,
  input  logic [31:0]              StData,
  input  logic [31:0]              StPC,
  output logic                     StStall,
  input  logic                     LdReq,
  input  logic [31:0]              LdAddr,
  output logic                     LdHit,
  output logic [31:0]              LdData,
  input  logic                     DrainEn,
  output logic                     MemWrite,
  output logic [31:0]              Addr,
  output logic [31:0]              WriteData,
  output logic [31:0]              PC,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count
);
  localparam int PW = $clog2(DEPTH);
  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d [DEPTH];
  logic [1:0]       lo_q [DEPTH];
  logic [1:0]       lo_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PW:0]      count_q, count_d;
  logic             enq, m_hit;
  logic [31:0]      m_data;
  assign Count = count_q;
  assign Empty = count_q == '0;
  assign Full = count_q == (PW+1)'(DEPTH);
  assign StStall = StReq && Full;
  assign enq = StReq && !Full && !Rst;
  assign MemWrite = !Empty && DrainEn && !Rst;
  // Low address bits live beside the record so Addr reproduces the full store address.
  assign Addr = {ent_q[head_q].addr, lo_q[head_q]};
  assign WriteData = ent_q[head_q].data;
  assign PC = ent_q[head_q].pc;
  assign LdHit = LdReq && m_hit;
  assign LdData = LdHit ? m_data : '0;
  store_buffer_match #(.DEPTH(DEPTH)) u_match (
    .ents    (ent_q),
    .valid   (valid_q),
    .head    (head_q),
    .count   (count_q),
    .ld_word (LdAddr[31:2]),
    .hit     (m_hit),
    .data    (m_data)
  );
  always_comb begin
    ent_d = ent_q;
    lo_d = lo_q;
    valid_d = valid_q;
    head_d = head_q;
    tail_d = tail_q;
    if (MemWrite) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (enq) begin
      ent_d[tail_q] = '{addr: StAddr[31:2], data: StData, pc: StPC};
      lo_d[tail_q] = StAddr[1:0];
      valid_d[tail_q] = 1'b1;
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + (PW+1)'(enq) - (PW+1)'(MemWrite);
  end
  always_ff @(posedge Clk) begin
    ent_q <= ent_d;
    lo_q <= lo_d;
    if (Rst) begin
      valid_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed self-checking bench for store_buffer.
module tb_store_buffer;
  logic        Clk = 1'b0, Rst = 1'b0;
  logic        StReq = 1'b0, LdReq = 1'b0, DrainEn = 1'b0;
  logic [31:0] StAddr = '0, StData = '0, StPC = '0, LdAddr = '0;
  logic        StStall, LdHit, MemWrite, Empty, Full;
  logic [31:0] LdData, Addr, WriteData, PC;
  logic [2:0]  Count;
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  int checks = 0, fails = 0;

  store_buffer #(.DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .StReq(StReq), .StAddr(StAddr), .StData(StData), .StPC(StPC),
    .StStall(StStall), .LdReq(LdReq), .LdAddr(LdAddr), .LdHit(LdHit), .LdData(LdData),
    .DrainEn(DrainEn), .MemWrite(MemWrite), .Addr(Addr), .WriteData(WriteData), .PC(PC),
    .Empty(Empty), .Full(Full), .Count(Count)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (MemWrite) begin
    log_a.push_back(Addr);
    log_d.push_back(WriteData);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    StReq = 1'b1; StAddr = a; StData = d; StPC = a + 32'h1000;
    tick();
    StReq = 1'b0;
  endtask

  task automatic drain_all();
    DrainEn = 1'b1;
    for (int i = 0; i < 12 && !Empty; i++) tick();
    DrainEn = 1'b0;
    #1;
    chk("drain_empty", {31'd0, Empty}, 32'd1);
  endtask

  initial begin
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    LdReq = 1'b1; LdAddr = 32'h10;
    #1;
    chk("rst_empty", {31'd0, Empty}, 32'd1);
    chk("rst_full", {31'd0, Full}, 32'd0);
    chk("rst_count", {29'd0, Count}, 32'd0);
    chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    chk("rst_ststall", {31'd0, StStall}, 32'd0);
    chk("rst_ldhit", {31'd0, LdHit}, 32'd0);
    LdReq = 1'b0;

    // two stores, then drain in order
    st(32'h10, 32'h1111_1111);
    st(32'h14, 32'h2222_2222);
    #1;
    chk("t1_count", {29'd0, Count}, 32'd2);
    chk("t1_nowrite", {31'd0, MemWrite}, 32'd0);
    DrainEn = 1'b1;
    #1;
    chk("t1_mw0", {31'd0, MemWrite}, 32'd1);
    chk("t1_addr0", Addr, 32'h10);
    chk("t1_data0", WriteData, 32'h1111_1111);
    chk("t1_pc0", PC, 32'h1010);
    tick();
    chk("t1_mw1", {31'd0, MemWrite}, 32'd1);
    chk("t1_addr1", Addr, 32'h14);
    chk("t1_data1", WriteData, 32'h2222_2222);
    tick();
    chk("t1_empty", {31'd0, Empty}, 32'd1);
    chk("t1_mw_off", {31'd0, MemWrite}, 32'd0);
    DrainEn = 1'b0;

    // fill, stall, stall-with-drain, then accept
    log_a.delete(); log_d.delete();
    for (int i = 0; i < 4; i++) st(32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
    #1;
    chk("t2_full", {31'd0, Full}, 32'd1);
    StReq = 1'b1; StAddr = 32'h50; StData = 32'hA4; StPC = 32'h1050;
    #1;
    chk("t2_stall", {31'd0, StStall}, 32'd1);
    tick();
    chk("t2_count4", {29'd0, Count}, 32'd4);
    DrainEn = 1'b1;
    #1;
    chk("t2_stall_drain", {31'd0, StStall}, 32'd1);
    chk("t2_mw", {31'd0, MemWrite}, 32'd1);
    tick();
    chk("t2_count3", {29'd0, Count}, 32'd3);
    chk("t2_nostall", {31'd0, StStall}, 32'd0);
    tick();
    chk("t2_count_acc", {29'd0, Count}, 32'd3);
    StReq = 1'b0;
    drain_all();
    chk("t2_log_n", log_a.size(), 32'd5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) begin
      chk("t2_log_a", log_a[i], 32'h40 + 32'(4 * i));
      chk("t2_log_d", log_d[i], 32'hA0 + 32'(i));
    end

    // head now at slot 3: steady-state enqueue+drain across wrap
    log_a.delete(); log_d.delete();
    for (int i = 0; i < 3; i++) st(32'h100 + 32'(4 * i), 32'hC000_0000 + 32'(i));
    #1;
    chk("t3_count", {29'd0, Count}, 32'd3);
    DrainEn = 1'b1;
    for (int i = 3; i < 11; i++) begin
      StReq = 1'b1; StAddr = 32'h100 + 32'(4 * i); StData = 32'hC000_0000 + 32'(i);
      tick();
      chk("t3_steady", {29'd0, Count}, 32'd3);
    end
    StReq = 1'b0;
    drain_all();
    chk("t3_log_n", log_a.size(), 32'd11);
    for (int i = 0; i < 11 && i < log_a.size(); i++) begin
      chk("t3_log_a", log_a[i], 32'h100 + 32'(4 * i));
      chk("t3_log_d", log_d[i], 32'hC000_0000 + 32'(i));
    end

    // youngest-match forwarding
    st(32'h20, 32'hAAAA_0000);
    st(32'h20, 32'hBBBB_0000);
    LdReq = 1'b1; LdAddr = 32'h22;
    #1;
    chk("t4_hit", {31'd0, LdHit}, 32'd1);
    chk("t4_data", LdData, 32'hBBBB_0000);
    LdAddr = 32'h24;
    #1;
    chk("t4_miss", {31'd0, LdHit}, 32'd0);
    chk("t4_miss_data", LdData, 32'd0);
    LdReq = 1'b0; LdAddr = 32'h20;
    #1;
    chk("t4_noreq", {31'd0, LdHit}, 32'd0);
    chk("t4_noreq_data", LdData, 32'd0);
    drain_all();

    // reset mid-drain discards everything
    st(32'h61, 32'h77);
    st(32'h64, 32'h88);
    log_a.delete(); log_d.delete();
    DrainEn = 1'b1;
    #1;
    chk("t5_mw", {31'd0, MemWrite}, 32'd1);
    chk("t5_full_addr", Addr, 32'h61);
    Rst = 1'b1; StReq = 1'b1; StAddr = 32'h68; StData = 32'h99;
    #1;
    chk("t5_mw_rst", {31'd0, MemWrite}, 32'd0);
    tick();
    Rst = 1'b0; StReq = 1'b0; DrainEn = 1'b0;
    #1;
    chk("t5_count", {29'd0, Count}, 32'd0);
    chk("t5_empty", {31'd0, Empty}, 32'd1);
    chk("t5_no_write", log_a.size(), 32'd0);
    LdReq = 1'b1; LdAddr = 32'h64;
    #1;
    chk("t5_ld64", {31'd0, LdHit}, 32'd0);
    LdAddr = 32'h68;
    #1;
    chk("t5_ld68", {31'd0, LdHit}, 32'd0);

    // same-cycle store is not forwarded
    StReq = 1'b1; StAddr = 32'h30; StData = 32'h5; LdAddr = 32'h30;
    #1;
    chk("t6_same", {31'd0, LdHit}, 32'd0);
    tick();
    StReq = 1'b0;
    #1;
    chk("t6_next", {31'd0, LdHit}, 32'd1);
    chk("t6_data", LdData, 32'h5);
    LdReq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
